// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_pkg : shared constants and fetch FSM encoding for the fetch stage
// Revision     : 1.0
// ============================================================================
package pipeline_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INST           = 32'h0000_0000;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : prefetch FIFO of {pc,inst} entries with push/pop/flush
// Revision   : 1.0
// ============================================================================
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked solely by cnt.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  assign rdata = mem[rptr];
  assign count = cnt;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : fetch PC, single-outstanding imem reads, prefetch FIFO, IF/ID reg
// Revision   : 1.0
// ============================================================================
module inst_fetch
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pause,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_nxt;
  logic [31:0]   fpc;
  logic [31:0]   drop_addr;
  logic [31:0]   redirect_word;
  logic          push_ok;
  logic          pop_fire;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          unused_fifo_full;
  logic          unused_redirect_lsb;
  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_head;
  logic [63:0]   out_word;
  logic [CW:0]   free_slots;

  assign redirect_word       = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign push_ok  = (state == REQ) && imem_ack && !redirect;
  assign pop_fire = !redirect && !pause && (!fifo_empty || push_ok);
  // An arriving word that is consumed immediately bypasses the FIFO storage.
  assign fifo_push = push_ok && !(fifo_empty && pop_fire);
  assign fifo_pop  = pop_fire && !fifo_empty;
  assign out_word  = fifo_empty ? {fpc, imem_rdata} : fifo_head;

  assign free_slots = (CW+1)'(FIFO_DEPTH) - {1'b0, fifo_count} + {{CW{1'b0}}, pop_fire};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata ({fpc, imem_rdata}),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (unused_fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!redirect && (free_slots != '0)) state_nxt = REQ;
      end
      REQ: begin
        if (redirect)      state_nxt = imem_ack ? IDLE : DROP;
        else if (imem_ack) state_nxt = (free_slots > (CW+1)'(1)) ? REQ : IDLE;
      end
      DROP: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fpc;
    case (state)
      REQ:  imem_req = 1'b1;
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // The abandoned request keeps its address on the bus until memory acks it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc       <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      if (redirect)     fpc <= redirect_word;
      else if (push_ok) fpc <= fpc + 32'd4;
      if ((state == REQ) && !imem_ack && redirect) drop_addr <= fpc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_o  <= NOP_INST;
      pc_o    <= 32'h0;
      valid_o <= 1'b0;
    end else if (redirect) begin
      valid_o <= 1'b0;
    end else if (!pause) begin
      if (pop_fire) begin
        pc_o    <= out_word[63:32];
        inst_o  <= out_word[31:0];
        valid_o <= 1'b1;
      end else begin
        inst_o  <= NOP_INST;
        valid_o <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch : directed stimulus with scoreboard for inst_fetch
// Revision      : 1.0
// ============================================================================
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        pause;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        valid_o;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int wcnt = 0;

  logic [63:0] sb [$];
  logic        dropping = 1'b0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pause       (pause),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      step();
      if (valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Memory: acks after ack_delay waiting cycles; checks address discipline.
  logic        m_prev_req = 1'b0;
  logic [31:0] m_prev_addr = 32'h0;
  always @(negedge clk) begin
    if (!rst) begin
      imem_ack   = 1'b0;
      wcnt       = 0;
      m_prev_req = 1'b0;
    end else begin
      if (imem_req) begin
        check("addr_align", {62'h0, imem_addr[1:0]}, 64'h0);
        if (m_prev_req && !imem_ack) check("addr_stable", imem_addr, m_prev_addr);
      end
      if (!imem_req || imem_ack) wcnt = 0;
      if (imem_req) begin
        imem_ack   = (wcnt >= ack_delay);
        imem_rdata = mem_word(imem_addr);
        wcnt++;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
      end
      m_prev_req  = imem_req;
      m_prev_addr = imem_addr;
    end
  end

  // Scoreboard: accepted words queued at the edge, compared when presented.
  logic        s_acc, s_rd, s_pause, s_req, s_valid;
  logic [31:0] s_addr, s_data, s_inst, s_pc;
  logic [63:0] s_exp;
  always @(posedge clk) begin
    if (rst) begin
      s_acc   = imem_req && imem_ack;
      s_req   = imem_req;
      s_rd    = redirect;
      s_pause = pause;
      s_addr  = imem_addr;
      s_data  = imem_rdata;
      s_inst  = inst_o;
      s_pc    = pc_o;
      s_valid = valid_o;
      #1;
      if (s_rd) begin
        sb.delete();
        check("redirect_bubble", {63'h0, valid_o}, 64'h0);
      end else begin
        if (s_acc && !dropping) sb.push_back({s_addr, s_data});
        if (s_pause) begin
          check("pause_hold_valid", {63'h0, valid_o}, {63'h0, s_valid});
          check("pause_hold_pc", {32'h0, pc_o}, {32'h0, s_pc});
          check("pause_hold_inst", {32'h0, inst_o}, {32'h0, s_inst});
        end else if (sb.size() > 0) begin
          s_exp = sb.pop_front();
          check("out_valid", {63'h0, valid_o}, 64'h1);
          check("out_pc_inst", {pc_o, inst_o}, s_exp);
        end else begin
          check("bubble_valid", {63'h0, valid_o}, 64'h0);
          check("bubble_inst", {32'h0, inst_o}, 64'h0);
        end
      end
      if (s_acc) dropping = 1'b0;
      else if (s_rd && s_req) dropping = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ok;
    int          nvalid;
    logic [31:0] held_addr;

    rst = 1'b0; pause = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) step();
    check("rst_req",   {63'h0, imem_req}, 64'h0);
    check("rst_valid", {63'h0, valid_o}, 64'h0);
    check("rst_inst",  {32'h0, inst_o}, 64'h0);
    check("rst_pc",    {32'h0, pc_o}, 64'h0);

    rst = 1'b1;
    step();
    check("first_req",    {63'h0, imem_req}, 64'h1);
    check("first_addr",   {32'h0, imem_addr}, 64'h0);
    check("first_bubble", {63'h0, valid_o}, 64'h0);
    step();
    check("first_valid", {63'h0, valid_o}, 64'h1);
    check("first_pc",    {32'h0, pc_o}, 64'h0);
    step();
    check("second_pc", {32'h0, pc_o}, 64'h4);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stream_valid", {63'h0, valid_o}, 64'h1);
      check("stream_pc", {32'h0, pc_o}, {32'h0, 32'(8 + 4*i)});
    end

    ack_delay = 3;
    repeat (8) step();
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (valid_o) nvalid++;
    end
    check("delay_rate", 64'(nvalid), 64'd4);

    ack_delay = 0;
    repeat (6) step();
    pause = 1'b1;
    repeat (5) step();
    check("pause_req_drop", {63'h0, imem_req}, 64'h0);
    pause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("unpause_valid", {63'h0, valid_o}, 64'h1);
    end

    ack_delay = 1000;
    repeat (4) step();
    check("drop_pre_req", {63'h0, imem_req}, 64'h1);
    held_addr = imem_addr;
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    check("drop_req_held",  {63'h0, imem_req}, 64'h1);
    check("drop_addr_held", {32'h0, imem_addr}, {32'h0, held_addr});
    repeat (2) step();
    ack_delay = 0;
    wait_valid(20, ok);
    check("drop_timeout", {63'h0, ok}, 64'h1);
    check("drop_next_pc", {32'h0, pc_o}, 64'h100);

    repeat (3) step();
    pause = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0; pause = 1'b0;
    check("rp_valid", {63'h0, valid_o}, 64'h0);
    wait_valid(20, ok);
    check("rp_timeout", {63'h0, ok}, 64'h1);
    check("rp_pc", {32'h0, pc_o}, 64'h200);

    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    wait_valid(20, ok);
    check("wrap_timeout", {63'h0, ok}, 64'h1);
    check("wrap_pc_top", {32'h0, pc_o}, 64'hFFFF_FFFC);
    step();
    check("wrap_valid", {63'h0, valid_o}, 64'h1);
    check("wrap_pc_zero", {32'h0, pc_o}, 64'h0);

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
